// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM encoding, default frame
// width and the clock/baud figures that benches use to relate bit time to real time.
package uart_pkg;

  localparam int UART_DATA_BITS_DEF = 8;
  localparam int UART_CLK_FREQ_HZ   = 100_000_000;
  localparam int UART_BAUD_RATE     = 115_200;

  // The ST_ prefix keeps ST_DATA_BITS apart from the DATA_BITS width parameter.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START_BIT = 2'd1,
    ST_DATA_BITS = 2'd2,
    ST_STOP_BIT  = 2'd3
  } uart_tx_state_e;

endpackage

// File: rtl/uart8_transmitter.sv
// 8N1 serial transmitter clocked at the baud rate: one clk cycle is one bit time.
// Every output is a flop, so the TX line never sees a combinational path from the inputs.
module uart8_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] in,
  output logic                 out,
  output logic                 done,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DATA_BITS) + 1;

  uart_tx_state_e       state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 out_q, out_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      out_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // The outputs are computed for the state being entered, so the registered
  // values line up with that state's bit time.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    out_d   = 1'b1;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      shreg_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_START_BIT;
            shreg_d = in;
            cnt_d   = '0;
            out_d   = 1'b0;
            busy_d  = 1'b1;
          end
        end
        ST_START_BIT: begin
          state_d = ST_DATA_BITS;
          out_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          busy_d  = 1'b1;
        end
        ST_DATA_BITS: begin
          busy_d = 1'b1;
          // cnt_q counts data bits already on the line.
          if (cnt_q == CNT_W'(DATA_BITS)) begin
            state_d = ST_STOP_BIT;
            out_d   = 1'b1;
          end else begin
            out_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + 1'b1;
          end
        end
        ST_STOP_BIT: begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart8_transmitter.sv
// Directed bench for uart8_transmitter: frames queued on send, popped and checked bit by bit.
module tb_uart8_transmitter;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic       start = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dout, done, busy;

  int checks = 0;
  int errors = 0;
  int gap;
  logic [7:0] exp_q[$];
  logic [7:0] junk;

  uart8_transmitter #(.DATA_BITS(8)) dut (
    .clk(clk), .rstn(rstn), .en(en), .start(start), .in(din),
    .out(dout), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_out"}, {7'd0, dout}, 8'h01);
    chk({tag, "_busy"}, {7'd0, busy}, 8'h00);
    chk({tag, "_done"}, {7'd0, done}, 8'h00);
  endtask

  // Raise start for one edge; afterwards 'in' is scrambled to prove capture.
  task automatic send(input logic [7:0] d);
    tick();
    din = d; start = 1'b1;
    exp_q.push_back(d);
    tick();
    start = 1'b0; din = 8'hFF;
  endtask

  // Expects to be called at or before the start-bit cycle; checks through done.
  task automatic recv_frame(input string tag);
    logic [7:0] d;
    int n;
    n = 0;
    while (!(busy === 1'b1 && dout === 1'b0) && n < 20) begin tick(); n++; end
    gap = n;
    chk({tag, "_start_seen"}, {7'd0, (busy === 1'b1 && dout === 1'b0)}, 8'h01);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 8'h00, 8'h01);
      d = 8'h00;
    end else d = exp_q.pop_front();
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("%s_bit%0d", tag, i), {7'd0, dout}, {7'd0, d[i]});
      chk($sformatf("%s_busy%0d", tag, i), {7'd0, busy}, 8'h01);
    end
    tick();
    chk({tag, "_stop"}, {6'd0, dout, busy}, 8'h03);
    chk({tag, "_stop_done"}, {7'd0, done}, 8'h00);
    tick();
    chk({tag, "_done_pulse"}, {5'd0, dout, busy, done}, 8'h05);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with start and en high: line must stay idle.
    rstn = 1'b0; en = 1'b1; start = 1'b1; din = 8'h5A;
    for (int i = 0; i < 4; i++) begin tick(); chk_idle($sformatf("rst%0d", i)); end
    start = 1'b0;
    #3 rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin tick(); chk_idle($sformatf("post_rst%0d", i)); end

    // 0x55 single frame.
    send(8'h55);
    recv_frame("f55");
    tick();
    chk_idle("after55");

    // 0x96 with 'in' forced to 0xFF after capture.
    send(8'h96);
    recv_frame("f96");

    // start held high: three frames with exactly one idle cycle between them.
    tick();
    din = 8'hA3; start = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(8'hA3);
    recv_frame("rep0");
    recv_frame("rep1");
    chk("rep1_gap", gap[7:0], 8'd1);
    recv_frame("rep2");
    chk("rep2_gap", gap[7:0], 8'd1);
    start = 1'b0;
    tick();
    chk_idle("rep_end");

    // en drop during data bit 3 aborts the frame.
    send(8'h00);
    junk = exp_q.pop_front();
    chk("abort_startbit", {6'd0, dout, busy}, 8'h01);
    for (int i = 0; i < 4; i++) tick();
    chk("abort_bit3", {6'd0, dout, busy}, 8'h01);
    en = 1'b0;
    tick();
    chk_idle("abort0");
    tick();
    chk_idle("abort1");
    en = 1'b1;
    send(8'h3C);
    recv_frame("f3c");

    // Asynchronous reset mid-data with the line low.
    send(8'h00);
    junk = exp_q.pop_front();
    tick(); tick(); tick();
    chk("areset_pre", {6'd0, dout, busy}, 8'h01);
    #2 rstn = 1'b0;
    #1;
    chk("areset_out", {7'd0, dout}, 8'h01);
    chk("areset_busy", {7'd0, busy}, 8'h00);
    tick();
    chk_idle("areset_hold");
    #3 rstn = 1'b1;
    tick();
    chk_idle("areset_rel");
    send(8'hC5);
    recv_frame("fc5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
